legv8_fetch_unit: RTL and testbench
===================================

Name: legv8_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the LEGv8 control unit.
- Owns the program counter and requests 32-bit instruction words from instruction memory over a req/ack handshake.
- Holds each fetched word stable on `instruction` until the control unit signals `advance`, then computes the next PC from the control unit's PC-select field, `constant` and a register target.
- Provides `pc_current` and `pc_plus4` (BL link value) to the datapath.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- ADDR_W, 64, PC/address width. All PC arithmetic is modulo 2^ADDR_W.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- pc_sel  input  2  next-PC select, sampled only on advance: 00 PC+4, 01 PC+constant, 10 reg_target, 11 halt
- constant  input  ADDR_W  sign-extended byte offset for a taken branch (from control unit)
- reg_target  input  ADDR_W  register value for BR
- advance  input  1  control unit is done with the current instruction
- imem_rdata  input  32  instruction memory read data, valid when imem_ack=1
- imem_ack  input  1  memory accepts the request and returns data in the same cycle
- imem_req  output  1  fetch request
- imem_addr  output  ADDR_W  fetch address, always equal to PC
- instruction  output  32  held instruction word to the control unit
- instr_valid  output  1  `instruction` is valid
- pc_current  output  ADDR_W  PC of the held or in-flight instruction
- pc_plus4  output  ADDR_W  combinational pc_current+4
- halted  output  1  unit is in HALT
- align_fault  output  1  sticky misaligned-target flag (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, PC=RESET_PC, imem_req=0, instruction=32'h0, instr_valid=0, halted=0, align_fault=0. Asserting reset mid-fetch aborts the fetch; imem_req drops immediately.
- FSM states: IDLE, FETCH, HOLD, HALT, FAULT.
- IDLE: on the first rising edge with reset=1, go to FETCH.
- FETCH:
  - imem_req=1 (registered), imem_addr=PC, held stable until ack.
  - On an edge with imem_ack=1: instruction<=imem_rdata, instr_valid<=1, imem_req<=0, go to HOLD.
  - advance is ignored in FETCH.
  - Minimum fetch latency: req rises at edge N; ack sampled at edge N+1 gives instr_valid=1 after edge N+1.
- HOLD:
  - instruction, instr_valid=1 and PC stay stable until advance=1 at an edge.
  - On advance, select next PC:
    - 00: PC+4
    - 01: PC+constant (two's complement add, wraps)
    - 10: reg_target
    - 11: go to HALT, PC unchanged
  - For 00/01/10: PC<=next, instr_valid<=0, imem_req<=1, go to FETCH. Exactly one idle-valid cycle separates instructions.
- HALT: instr_valid=0, imem_req=0, halted=1. Exit only via reset.
- imem_ack while imem_req=0 is ignored.
- pc_sel, constant and reg_target are don't-care except on an edge where state=HOLD and advance=1.
- instruction retains its last value while instr_valid=0.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined: on advance in HOLD with pc_sel=01/10 and next-PC[1:0]!=2'b00:
  - go to FAULT, align_fault<=1 (sticky), PC not updated, instr_valid<=0, imem_req=0.
  - Exit FAULT only via reset.
- Undefined:
  - bits [1:0] of every loaded PC are forced to 2'b00.
  - align_fault is tied to 0.
  - FAULT state is absent.

Test Plan:
- Reset with RESET_PC=0, release, ack on the first req cycle with rdata=32'h91200000 (ADDI) -> imem_addr=0, instruction=32'h91200000, instr_valid=1 one edge after ack, pc_plus4=4.
- Hold ack low 3 cycles, then ack -> imem_req stays 1 with imem_addr stable for 4 cycles. advance pulsed during FETCH -> no effect.
- In HOLD at PC=0x100, pc_sel=01, constant=-64'd8, advance -> next imem_addr=0xF8. pc_sel=10, reg_target=0x2000 -> imem_addr=0x2000.
- PC=64'hFFFF_FFFF_FFFF_FFFC, pc_sel=00, advance -> PC wraps to 0.
- pc_sel=11 on advance -> halted=1, imem_req=0 permanently. Reset pulse low mid-FETCH -> imem_req=0 asynchronously, PC=RESET_PC.
- With FETCH_ALIGN_CHECK_EN: pc_sel=10, reg_target=0x2002 -> align_fault=1, no further req. Without it: the same stimulus fetches from 0x2000.

Source files
------------

// File: rtl/legv8_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// legv8_fetch_unit_if
//   Instruction-memory request/acknowledge bundle between the LEGv8 fetch unit
//   and instruction memory.
//
//   imem_req   : fetch request (fetch unit -> memory)
//   imem_addr  : fetch byte address, ADDR_W bits (fetch unit -> memory)
//   imem_rdata : 32-bit instruction word, valid with imem_ack (memory -> fetch unit)
//   imem_ack   : request accepted, data returned in the same cycle (memory -> fetch unit)
//
//   modport master : fetch-unit side
//   modport slave  : memory side
// ---------------------------------------------------------------------------
interface legv8_fetch_unit_if #(
  parameter int ADDR_W = 64
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/legv8_fetch_unit.sv
// ---------------------------------------------------------------------------
// legv8_fetch_unit
//   Instruction fetch stage feeding the LEGv8 control unit. Owns the PC,
//   fetches one 32-bit word per instruction over a req/ack handshake, holds it
//   until the control unit advances, then selects the next PC.
//
//   Parameters
//     ADDR_W   : PC / address width (PC arithmetic wraps modulo 2^ADDR_W)
//     RESET_PC : PC value loaded on reset
//
//   Ports
//     clock       : system clock, rising edge
//     reset       : asynchronous active-low reset
//     pc_sel      : next-PC select on advance (00 PC+4, 01 PC+constant,
//                   10 reg_target, 11 halt)
//     constant    : sign-extended branch byte offset
//     reg_target  : register value for BR
//     advance     : control unit is finished with the held instruction
//     imem        : instruction-memory handshake (master side)
//     instruction : held instruction word
//     instr_valid : instruction is valid
//     pc_current  : PC of the held / in-flight instruction
//     pc_plus4    : pc_current + 4 (BL link value)
//     halted      : unit is halted
//     align_fault : sticky misaligned branch-target flag
//
//   Build option
//     FETCH_ALIGN_CHECK_EN : when defined, a PC+constant or reg_target target
//     with nonzero bits [1:0] traps into a terminal FAULT state and raises
//     align_fault. When undefined, bits [1:0] of every loaded PC are cleared
//     and align_fault is tied low.
// ---------------------------------------------------------------------------
module legv8_fetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          pc_sel,
  input  logic [ADDR_W-1:0]   constant,
  input  logic [ADDR_W-1:0]   reg_target,
  input  logic                advance,
  legv8_fetch_unit_if.master  imem,
  output logic [31:0]         instruction,
  output logic                instr_valid,
  output logic [ADDR_W-1:0]   pc_current,
  output logic [ADDR_W-1:0]   pc_plus4,
  output logic                halted,
  output logic                align_fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_HALT
`ifdef FETCH_ALIGN_CHECK_EN
    ,S_FAULT
`endif
  } state_t;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [ADDR_W-1:0] RESET_PC_LOAD = RESET_PC;
`else
  // Word alignment is enforced by clearing the two low PC bits on every load.
  localparam logic [ADDR_W-1:0] ALIGN_MASK    = ~(ADDR_W'(3));
  localparam logic [ADDR_W-1:0] RESET_PC_LOAD = RESET_PC & ALIGN_MASK;
`endif

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       instr_q;
  logic              valid_q;
  logic              req_q;
  logic              halted_q;
  logic [ADDR_W-1:0] target_d;
  logic [ADDR_W-1:0] next_pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic              fault_q;
  logic              misaligned_d;
`endif

  // Candidate next PC; only consumed on an advance edge while holding.
  always_comb begin
    target_d = pc_q + ADDR_W'(4);
    case (pc_sel)
      2'b01:   target_d = pc_q + constant;
      2'b10:   target_d = reg_target;
      default: target_d = pc_q + ADDR_W'(4);
    endcase
`ifdef FETCH_ALIGN_CHECK_EN
    next_pc_d    = target_d;
    // Sequential PC+4 is never checked; only taken-branch targets are.
    misaligned_d = ((pc_sel == 2'b01) || (pc_sel == 2'b10)) &&
                   (target_d[1:0] != 2'b00);
`else
    next_pc_d    = target_d & ALIGN_MASK;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC_LOAD;
      req_q    <= 1'b0;
      instr_q  <= 32'h0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          req_q   <= 1'b1;
          state_q <= S_FETCH;
        end

        S_FETCH: begin
          // Address and request stay put until memory acknowledges.
          if (imem.imem_ack) begin
            instr_q <= imem.imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (advance) begin
            valid_q <= 1'b0;
            if (pc_sel == 2'b11) begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            else if (misaligned_d) begin
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end
`endif
            else begin
              pc_q    <= next_pc_d;
              req_q   <= 1'b1;
              state_q <= S_FETCH;
            end
          end
        end

        S_HALT: begin
        end

`ifdef FETCH_ALIGN_CHECK_EN
        S_FAULT: begin
        end
`endif

        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instruction    = instr_q;
  assign instr_valid    = valid_q;
  assign pc_current     = pc_q;
  assign pc_plus4       = pc_q + ADDR_W'(4);
  assign halted         = halted_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign align_fault    = fault_q;
`else
  assign align_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_legv8_fetch_unit.sv
module tb_legv8_fetch_unit;
  localparam int ADDR_W = 64;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [1:0]        pc_sel = 2'b00;
  logic [ADDR_W-1:0] constant_v = '0;
  logic [ADDR_W-1:0] reg_target = '0;
  logic              advance = 1'b0;
  logic [31:0]       instruction;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc_current;
  logic [ADDR_W-1:0] pc_plus4;
  logic              halted;
  logic              align_fault;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  legv8_fetch_unit_if #(.ADDR_W(ADDR_W)) imem_if ();

  legv8_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(64'h0)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc_sel      (pc_sel),
    .constant    (constant_v),
    .reg_target  (reg_target),
    .advance     (advance),
    .imem        (imem_if.master),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc_current  (pc_current),
    .pc_plus4    (pc_plus4),
    .halted      (halted),
    .align_fault (align_fault)
  );

  always #5 clock = ~clock;

  // Instruction memory contents: address 0 holds ADDI, elsewhere a hash.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h9120_0000;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0123_4567;
  endfunction

  initial imem_if.imem_ack = 1'b0;
  assign imem_if.imem_rdata = mem_word(imem_if.imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [63:0] m_pc = 64'h0;
  logic        m_started = 1'b0;
  logic        m_req = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = 32'h0;
  logic        m_halted = 1'b0;
  logic        m_fault = 1'b0;

  function automatic logic [63:0] branch_target(input logic [1:0] sel, input logic [63:0] pc,
                                                input logic [63:0] c, input logic [63:0] rt);
    if (sel == 2'b01) return pc + c;
    if (sel == 2'b10) return rt;
    return pc + 64'd4;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pc      <= 64'h0;
      m_started <= 1'b0;
      m_req     <= 1'b0;
      m_valid   <= 1'b0;
      m_instr   <= 32'h0;
      m_halted  <= 1'b0;
      m_fault   <= 1'b0;
    end else if (!m_started) begin
      m_started <= 1'b1;
      m_req     <= 1'b1;
    end else if (m_halted || m_fault) begin
      m_req <= 1'b0;
    end else if (m_req) begin
      if (imem_if.imem_ack) begin
        m_instr <= mem_word(m_pc);
        m_valid <= 1'b1;
        m_req   <= 1'b0;
      end
    end else if (m_valid && advance) begin
      m_valid <= 1'b0;
      if (pc_sel == 2'b11) begin
        m_halted <= 1'b1;
      end else begin
`ifdef FETCH_ALIGN_CHECK_EN
        if (pc_sel != 2'b00 && branch_target(pc_sel, m_pc, constant_v, reg_target) % 4 != 0) begin
          m_fault <= 1'b1;
        end else begin
          m_pc  <= branch_target(pc_sel, m_pc, constant_v, reg_target);
          m_req <= 1'b1;
        end
`else
        m_pc  <= branch_target(pc_sel, m_pc, constant_v, reg_target) / 4 * 4;
        m_req <= 1'b1;
`endif
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      chk("imem_req",    {63'h0, imem_if.imem_req}, {63'h0, m_req});
      chk("imem_addr",   imem_if.imem_addr, m_pc);
      chk("instruction", {32'h0, instruction}, {32'h0, m_instr});
      chk("instr_valid", {63'h0, instr_valid}, {63'h0, m_valid});
      chk("pc_current",  pc_current, m_pc);
      chk("pc_plus4",    pc_plus4, m_pc + 64'd4);
      chk("halted",      {63'h0, halted}, {63'h0, m_halted});
      chk("align_fault", {63'h0, align_fault}, {63'h0, m_fault});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic adv(input logic [1:0] sel, input logic [63:0] c, input logic [63:0] rt);
    pc_sel = sel; constant_v = c; reg_target = rt;
    advance = 1'b1; imem_if.imem_ack = 1'b0;
    cyc();
    advance = 1'b0;
  endtask

  task automatic fetch_now();
    imem_if.imem_ack = 1'b1;
    cyc();
    imem_if.imem_ack = 1'b0;
  endtask

  function automatic logic [63:0] rand_const();
    int k;
    int off;
    logic [63:0] v;
    k = int'($urandom_range(0, 7));
    off = int'($urandom_range(0, 511)) - 256;
    v = 64'(longint'(off * 4));
    if (k == 0) v = {$urandom(), $urandom()};
    else if (k == 1) v = v + 64'($urandom_range(1, 3));
    return v;
  endfunction

  function automatic logic [63:0] rand_target();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    if ($urandom_range(0, 5) != 0) v[1:0] = 2'b00;
    return v;
  endfunction

  initial begin
    int stuck;
    int r;
    repeat (3) cyc();
    chk_en = 1'b1;
    chk("rst_instr_valid", {63'h0, instr_valid}, 64'h0);
    chk("rst_imem_req", {63'h0, imem_if.imem_req}, 64'h0);

    // First fetch: ack held high from reset release; ignored until req rises.
    reset = 1'b1;
    imem_if.imem_ack = 1'b1;
    cyc();
    chk("t1_req", {63'h0, imem_if.imem_req}, 64'h1);
    chk("t1_addr", imem_if.imem_addr, 64'h0);
    chk("t1_valid_low", {63'h0, instr_valid}, 64'h0);
    cyc();
    chk("t1_instr", {32'h0, instruction}, 64'h9120_0000);
    chk("t1_valid", {63'h0, instr_valid}, 64'h1);
    chk("t1_pc_plus4", pc_plus4, 64'h4);

    // Stalled fetch; advance during FETCH must be ignored.
    adv(2'b00, 64'h0, 64'h0);
    chk("t2_req", {63'h0, imem_if.imem_req}, 64'h1);
    chk("t2_addr", imem_if.imem_addr, 64'h4);
    for (int i = 0; i < 3; i++) begin
      advance = 1'b1; pc_sel = 2'b11; imem_if.imem_ack = 1'b0;
      cyc();
      chk("t2_req_stall", {63'h0, imem_if.imem_req}, 64'h1);
      chk("t2_addr_stall", imem_if.imem_addr, 64'h4);
      chk("t2_not_halted", {63'h0, halted}, 64'h0);
    end
    advance = 1'b0;
    fetch_now();
    chk("t2_instr", {32'h0, instruction}, {32'h0, mem_word(64'h4)});

    // Branch and register targets.
    adv(2'b10, 64'h0, 64'h100);
    fetch_now();
    adv(2'b01, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0);
    chk("t3_branch_addr", imem_if.imem_addr, 64'hF8);
    fetch_now();
    chk("t3_branch_instr", {32'h0, instruction}, {32'h0, mem_word(64'hF8)});
    adv(2'b10, 64'h0, 64'h2000);
    chk("t3_br_addr", imem_if.imem_addr, 64'h2000);
    fetch_now();

    // PC wrap.
    adv(2'b10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    fetch_now();
    adv(2'b00, 64'h0, 64'h0);
    chk("t4_wrap_addr", imem_if.imem_addr, 64'h0);
    fetch_now();

    // Misaligned register target.
    adv(2'b10, 64'h0, 64'h2002);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("t5_align_fault", {63'h0, align_fault}, 64'h1);
    for (int i = 0; i < 3; i++) begin
      imem_if.imem_ack = 1'b1;
      cyc();
      chk("t5_no_req", {63'h0, imem_if.imem_req}, 64'h0);
    end
`else
    chk("t5_masked_addr", imem_if.imem_addr, 64'h2000);
    chk("t5_no_fault", {63'h0, align_fault}, 64'h0);
    fetch_now();
    chk("t5_valid", {63'h0, instr_valid}, 64'h1);
`endif

    // Asynchronous reset in the middle of a fetch.
    reset = 1'b0; imem_if.imem_ack = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    fetch_now();
    adv(2'b10, 64'h0, 64'h40);
    chk("t6_fetch_addr", imem_if.imem_addr, 64'h40);
    reset = 1'b0;
    #1;
    chk("t6_async_req", {63'h0, imem_if.imem_req}, 64'h0);
    chk("t6_async_pc", pc_current, 64'h0);
    cyc();
    reset = 1'b1;

    // Halt is terminal until reset.
    cyc();
    fetch_now();
    adv(2'b11, 64'h0, 64'h0);
    chk("t7_halted", {63'h0, halted}, 64'h1);
    chk("t7_req", {63'h0, imem_if.imem_req}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      imem_if.imem_ack = 1'b1; advance = 1'b1; pc_sel = 2'b00;
      cyc();
      chk("t7_stay_halted", {63'h0, halted}, 64'h1);
      chk("t7_stay_noreq", {63'h0, imem_if.imem_req}, 64'h0);
    end
    advance = 1'b0;
    reset = 1'b0;
    cyc();
    reset = 1'b1;

    // Randomized traffic checked every cycle by the compare process.
    stuck = 0;
    for (int i = 0; i < 4000; i++) begin
      imem_if.imem_ack = ($urandom_range(0, 2) == 0);
      advance = $urandom_range(0, 1) == 1;
      r = int'($urandom_range(0, 39));
      pc_sel = (r == 0) ? 2'b11 : (r < 14) ? 2'b00 : (r < 28) ? 2'b01 : 2'b10;
      constant_v = rand_const();
      reg_target = rand_target();
      if (m_halted || m_fault) stuck++;
      else stuck = 0;
      if (stuck > 6 || $urandom_range(0, 599) == 0) begin
        reset = 1'b0;
        stuck = 0;
      end else begin
        reset = 1'b1;
      end
      cyc();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
